// File: rtl/fft_sat_pkg.sv
// Shared arithmetic for the FFT output saturator: shift/round and clamp helpers.
// Helpers work on a wide signed type so any DIN/DOUT width combination can narrow the result.
package fft_sat_pkg;

    localparam int DIN_WIDTH_DEF  = 14;
    localparam int DOUT_WIDTH_DEF = 13;

    typedef logic signed [31:0] wide_t;

    function automatic wide_t sat_hi(input int w);
        return (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    endfunction

    function automatic wide_t sat_lo(input int w);
        return -(wide_t'(1) <<< (w - 1));
    endfunction

    localparam wide_t SAT_MAX = sat_hi(DOUT_WIDTH_DEF);
    localparam wide_t SAT_MIN = sat_lo(DOUT_WIDTH_DEF);

    // Arithmetic right shift with optional round-half-up; result fits in DIN_WIDTH+1 bits.
    function automatic wide_t round_shift(input wide_t din, input int s, input logic round_en);
        wide_t biased;
        biased = din;
        if (round_en && (s > 0)) begin
            biased = din + (wide_t'(1) <<< (s - 1));
        end
        return biased >>> s;
    endfunction

    function automatic wide_t sat_clamp(input wide_t v, input int w);
        if (v > sat_hi(w)) begin
            return sat_hi(w);
        end else if (v < sat_lo(w)) begin
            return sat_lo(w);
        end
        return v;
    endfunction

    function automatic logic sat_hit(input wide_t v, input int w);
        return (v > sat_hi(w)) || (v < sat_lo(w));
    endfunction

endpackage

// File: rtl/fft_sat_round_pipe_stage.sv
// Generic valid/ready register slice; accepts a new payload whenever it is empty
// or its current payload leaves in the same cycle.
module fft_pipe_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         valid_q;
    logic         valid_d;
    logic [W-1:0] data_q;
    logic [W-1:0] data_d;

    always_comb begin
        in_ready = !valid_q || out_ready;
        valid_d  = valid_q;
        data_d   = data_q;
        if (in_valid && in_ready) begin
            valid_d = 1'b1;
            data_d  = in_data;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: rtl/fft_sat_round_pipe.sv
// FFT butterfly output saturator: per-beat shift/round, clamp to DOUT_WIDTH,
// two-stage valid/ready pipeline and saturation statistics for block scaling.
module fft_sat_round_pipe
    import fft_sat_pkg::*;
#(
    parameter int DIN_WIDTH  = 14,
    parameter int DOUT_WIDTH = 13,
    parameter int NCH        = 64,
    parameter int SHIFT_MAX  = 3,
    parameter int SHIFT_W    = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NCH*DIN_WIDTH-1:0]  din,
    input  logic [SHIFT_W-1:0]        shift,
    input  logic                      round_en,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NCH*DOUT_WIDTH-1:0] dout,
    output logic                      sat_flag,
    output logic                      sat_sticky,
    output logic [CNT_WIDTH-1:0]      sat_count,
    input  logic                      clr_stats
);

    localparam int VW   = DIN_WIDTH + 1;
    localparam int S1_W = NCH * VW;
    localparam int S2_W = NCH * DOUT_WIDTH + 1;

    int                        s_eff;
    logic [S1_W-1:0]           s1_in_data;
    logic [S1_W-1:0]           s1_data;
    logic                      s1_valid;
    logic                      s2_in_ready;
    logic [NCH*DOUT_WIDTH-1:0] lane_dout;
    logic [NCH-1:0]            lane_hit;
    logic [S2_W-1:0]           s2_in_data;
    logic [S2_W-1:0]           s2_data;

    always_comb begin
        s_eff = (int'(shift) > SHIFT_MAX) ? SHIFT_MAX : int'(shift);
    end

    for (genvar k = 0; k < NCH; k++) begin : g_s1_lane
        logic signed [DIN_WIDTH-1:0] x;
        assign x = din[k*DIN_WIDTH +: DIN_WIDTH];
        assign s1_in_data[k*VW +: VW] = VW'(round_shift(wide_t'(x), s_eff, round_en));
    end

    fft_pipe_stage #(.W(S1_W)) u_s1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (s1_in_data),
        .out_valid (s1_valid),
        .out_ready (s2_in_ready),
        .out_data  (s1_data)
    );

    for (genvar k = 0; k < NCH; k++) begin : g_s2_lane
        logic signed [VW-1:0] v;
        assign v                                 = s1_data[k*VW +: VW];
        assign lane_dout[k*DOUT_WIDTH +: DOUT_WIDTH] = DOUT_WIDTH'(sat_clamp(wide_t'(v), DOUT_WIDTH));
        assign lane_hit[k]                       = sat_hit(wide_t'(v), DOUT_WIDTH);
    end

    assign s2_in_data = {|lane_hit, lane_dout};

    fft_pipe_stage #(.W(S2_W)) u_s2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s1_valid),
        .in_ready  (s2_in_ready),
        .in_data   (s2_in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (s2_data)
    );

    assign {sat_flag, dout} = s2_data;

    logic                 sat_sticky_q;
    logic                 sat_sticky_d;
    logic [CNT_WIDTH-1:0] sat_count_q;
    logic [CNT_WIDTH-1:0] sat_count_d;

    // Stats move only on consume, so a stalled clamped beat is counted once; clear wins.
    always_comb begin
        sat_sticky_d = sat_sticky_q;
        sat_count_d  = sat_count_q;
        if (clr_stats) begin
            sat_sticky_d = 1'b0;
            sat_count_d  = '0;
        end else if (out_valid && out_ready && sat_flag) begin
            sat_sticky_d = 1'b1;
            if (sat_count_q != '1) begin
                sat_count_d = sat_count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sat_sticky_q <= 1'b0;
            sat_count_q  <= '0;
        end else begin
            sat_sticky_q <= sat_sticky_d;
            sat_count_q  <= sat_count_d;
        end
    end

    assign sat_sticky = sat_sticky_q;
    assign sat_count  = sat_count_q;

endmodule

// File: tb/tb_fft_sat_round_pipe.sv
// Bench for fft_sat_round_pipe: directed cases plus random traffic against an
// arithmetic reference model and an in-order scoreboard.
module tb_fft_sat_round_pipe;

    typedef struct packed {
        logic [51:0] d;
        logic        f;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, round_en, out_valid, out_ready;
    logic        sat_flag, sat_sticky, clr_stats;
    logic [2:0]  shift;
    logic [55:0] din;
    logic [51:0] dout;
    logic [15:0] sat_count;

    logic        b_in_valid, b_in_ready, b_round_en, b_out_valid, b_out_ready;
    logic        b_sat_flag, b_sat_sticky, b_clr;
    logic [1:0]  b_shift;
    logic [13:0] b_din;
    logic [12:0] b_dout;
    logic [1:0]  b_sat_count;

    int   tests = 0;
    int   fails = 0;
    int   exp_cnt = 0;
    logic exp_sticky = 1'b0;
    exp_t q[$];

    always #5 clk = ~clk;

    fft_sat_round_pipe #(
        .DIN_WIDTH(14), .DOUT_WIDTH(13), .NCH(4), .SHIFT_MAX(3), .SHIFT_W(3), .CNT_WIDTH(16)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .din(din),
        .shift(shift), .round_en(round_en), .out_valid(out_valid), .out_ready(out_ready),
        .dout(dout), .sat_flag(sat_flag), .sat_sticky(sat_sticky), .sat_count(sat_count),
        .clr_stats(clr_stats)
    );

    fft_sat_round_pipe #(
        .DIN_WIDTH(14), .DOUT_WIDTH(13), .NCH(1), .SHIFT_MAX(3), .SHIFT_W(2), .CNT_WIDTH(2)
    ) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .din(b_din),
        .shift(b_shift), .round_en(b_round_en), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .dout(b_dout), .sat_flag(b_sat_flag), .sat_sticky(b_sat_sticky), .sat_count(b_sat_count),
        .clr_stats(b_clr)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [55:0] pk_in(input int a, input int b, input int c, input int d);
        int          v[4];
        logic [55:0] r;
        v = '{a, b, c, d};
        r = '0;
        for (int k = 0; k < 4; k++) r[k*14 +: 14] = 14'(v[k]);
        return r;
    endfunction

    function automatic logic [51:0] pk_out(input int a, input int b, input int c, input int d);
        int          v[4];
        logic [51:0] r;
        v = '{a, b, c, d};
        r = '0;
        for (int k = 0; k < 4; k++) r[k*13 +: 13] = 13'(v[k]);
        return r;
    endfunction

    // Reference: floor((x + bias) / 2^s), then clamp to [-4096, 4095].
    function automatic exp_t model4(input logic [55:0] d, input logic [2:0] sh, input logic rnd);
        exp_t e;
        e = '0;
        for (int k = 0; k < 4; k++) begin
            logic signed [13:0] xs;
            int x, s, num, dv, qv;
            xs  = d[k*14 +: 14];
            x   = xs;
            s   = (sh > 3'd3) ? 3 : int'(sh);
            num = (rnd && s > 0) ? x + 2**(s-1) : x;
            dv  = 2**s;
            qv  = num / dv;
            if ((num % dv != 0) && (num < 0)) qv = qv - 1;
            if (qv > 4095) begin
                qv  = 4095;
                e.f = 1'b1;
            end else if (qv < -4096) begin
                qv  = -4096;
                e.f = 1'b1;
            end
            e.d[k*13 +: 13] = 13'(qv);
        end
        return e;
    endfunction

    task automatic cycle(output logic acc);
        exp_t e;
        @(negedge clk);
        chk("stat_count", 64'(sat_count), 64'(exp_cnt));
        chk("stat_sticky", 64'(sat_sticky), 64'(exp_sticky));
        acc = in_valid && in_ready && !rst;
        if (rst) begin
            q.delete();
            exp_cnt    = 0;
            exp_sticky = 1'b0;
        end else begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("sb_spurious", 64'(out_valid), 64'd0);
                end else begin
                    chk("sb_dout", 64'(dout), 64'(q[0].d));
                    chk("sb_flag", 64'(sat_flag), 64'(q[0].f));
                    if (out_ready) begin
                        e = q.pop_front();
                        if (!clr_stats && e.f) begin
                            exp_sticky = 1'b1;
                            if (exp_cnt < 65535) exp_cnt++;
                        end
                    end
                end
            end
            if (clr_stats) begin
                exp_cnt    = 0;
                exp_sticky = 1'b0;
            end
            if (acc) q.push_back(model4(din, shift, round_en));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_one(input string tag, input logic [55:0] d, input logic [2:0] sh,
                            input logic rnd, input logic [51:0] ed, input logic ef);
        logic acc;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        din       = d;
        shift     = sh;
        round_en  = rnd;
        cycle(acc);
        chk({tag, "_acc"}, 64'(acc), 64'd1);
        chk({tag, "_lat1"}, 64'(out_valid), 64'd0);
        in_valid = 1'b0;
        cycle(acc);
        chk({tag, "_lat2"}, 64'(out_valid), 64'd1);
        chk({tag, "_dout"}, 64'(dout), 64'(ed));
        chk({tag, "_flag"}, 64'(sat_flag), 64'(ef));
        cycle(acc);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        acc;
        logic [55:0] bp[6];
        logic [51:0] held;
        logic        held_ok;
        int          idx;
        int          base;

        rst = 1'b1;
        in_valid = 1'b0; din = '0; shift = '0; round_en = 1'b0; out_ready = 1'b0; clr_stats = 1'b0;
        b_in_valid = 1'b0; b_din = '0; b_shift = '0; b_round_en = 1'b0; b_out_ready = 1'b0; b_clr = 1'b0;
        cycle(acc);
        cycle(acc);
        rst = 1'b0;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_dout", 64'(dout), 64'd0);
        chk("rst_flag", 64'(sat_flag), 64'd0);
        chk("rst_b_count", 64'(b_sat_count), 64'd0);

        send_one("pass", pk_in(100, -4096, 4095, 0), 3'd0, 1'b0, pk_out(100, -4096, 4095, 0), 1'b0);
        chk("pass_count", 64'(sat_count), 64'd0);
        send_one("clamp", pk_in(8191, -8192, 0, 0), 3'd0, 1'b0, pk_out(4095, -4096, 0, 0), 1'b1);
        chk("clamp_count", 64'(sat_count), 64'd1);
        chk("clamp_sticky", 64'(sat_sticky), 64'd1);
        send_one("rnd_on", pk_in(5, -5, 8191, 0), 3'd1, 1'b1, pk_out(3, -2, 4095, 0), 1'b1);
        send_one("rnd_off", pk_in(5, -5, 0, 0), 3'd1, 1'b0, pk_out(2, -3, 0, 0), 1'b0);
        send_one("sh7_rnd", pk_in(100, -100, 8191, -8192), 3'd7, 1'b1, pk_out(13, -12, 1024, -1024), 1'b0);
        send_one("sh4_trunc", pk_in(100, -100, 8191, -8192), 3'd4, 1'b0, pk_out(12, -13, 1023, -1024), 1'b0);

        // Backpressure: six beats, downstream stalled for five clocks.
        bp[0] = pk_in(8191, 0, 0, 0);
        for (int i = 1; i < 6; i++)
            bp[i] = pk_in(int'($urandom_range(0, 8000)) - 4000, int'($urandom_range(0, 8000)) - 4000,
                          int'($urandom_range(0, 8000)) - 4000, int'($urandom_range(0, 8000)) - 4000);
        base = exp_cnt;
        shift = 3'd0; round_en = 1'b0; out_ready = 1'b0;
        idx = 0; held = '0; held_ok = 1'b0;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            din = bp[idx];
            cycle(acc);
            if (acc) idx++;
            if (out_valid) begin
                if (!held_ok) begin
                    held = dout;
                    held_ok = 1'b1;
                end else begin
                    chk("bp_hold", 64'(dout), 64'(held));
                end
            end
        end
        chk("bp_accepted", 64'(idx), 64'd2);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_held_val", 64'(held), 64'(pk_out(4095, 0, 0, 0)));
        out_ready = 1'b1;
        for (int c = 0; c < 40 && idx < 6; c++) begin
            din = bp[idx];
            cycle(acc);
            if (acc) idx++;
        end
        chk("bp_all_sent", 64'(idx), 64'd6);
        in_valid = 1'b0;
        for (int c = 0; c < 4; c++) cycle(acc);
        chk("bp_drained", 64'(q.size()), 64'd0);
        chk("bp_count_once", 64'(sat_count), 64'(base + 1));

        // Random traffic with occasional stats clears.
        for (int c = 0; c < 400; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            din       = 56'({$urandom(), $urandom()});
            shift     = 3'($urandom_range(0, 7));
            round_en  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 9) < 7);
            clr_stats = ($urandom_range(0, 24) == 0);
            cycle(acc);
        end
        clr_stats = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 4; c++) cycle(acc);
        chk("rand_drained", 64'(q.size()), 64'd0);

        // Reset with both stages full.
        out_ready = 1'b0; in_valid = 1'b1; shift = 3'd0; round_en = 1'b0;
        din = pk_in(8191, 1, 2, 3);
        cycle(acc);
        din = pk_in(4, 5, 6, 7);
        cycle(acc);
        chk("mid_full_valid", 64'(out_valid), 64'd1);
        chk("mid_full_ready", 64'(in_ready), 64'd0);
        rst = 1'b1; in_valid = 1'b0;
        cycle(acc);
        rst = 1'b0;
        chk("mid_out_valid", 64'(out_valid), 64'd0);
        chk("mid_in_ready", 64'(in_ready), 64'd1);
        chk("mid_dout", 64'(dout), 64'd0);
        chk("mid_count", 64'(sat_count), 64'd0);
        chk("mid_sticky", 64'(sat_sticky), 64'd0);
        send_one("post_rst", pk_in(-1, 2, -3, 4), 3'd0, 1'b0, pk_out(-1, 2, -3, 4), 1'b0);

        // Narrow counter saturates at 3; clear beats a simultaneous clamped consume.
        b_out_ready = 1'b1; b_in_valid = 1'b1; b_din = 14'h1fff; b_shift = 2'd0;
        for (int c = 0; c < 5; c++) begin
            cycle(acc);
            if (c == 2) begin
                chk("b_in_ready", 64'(b_in_ready), 64'd1);
                chk("b_dout", 64'(b_dout), 64'd4095);
                chk("b_flag", 64'(b_sat_flag), 64'd1);
            end
        end
        b_in_valid = 1'b0;
        for (int c = 0; c < 4; c++) cycle(acc);
        chk("b_count_sat", 64'(b_sat_count), 64'd3);
        chk("b_sticky", 64'(b_sat_sticky), 64'd1);
        b_out_ready = 1'b0; b_in_valid = 1'b1;
        cycle(acc);
        b_in_valid = 1'b0;
        cycle(acc);
        chk("b_clr_pending", 64'(b_out_valid), 64'd1);
        b_out_ready = 1'b1; b_clr = 1'b1;
        cycle(acc);
        b_clr = 1'b0;
        chk("b_clr_count", 64'(b_sat_count), 64'd0);
        chk("b_clr_sticky", 64'(b_sat_sticky), 64'd0);
        chk("b_clr_consumed", 64'(b_out_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
